prbs_checker_multi: RTL and testbench

Parametrised, self-synchronising PRBS pattern checker for the ETROC2 readout link test path. Each cycle it takes a word of received serial data, predicts the word from the previously received bits using the selected polynomial (PRBS7/15/23/31), and reports per-bit and per-word errors. A search/lock state machine qualifies the link. Saturating counters accumulate bit errors, errored words and checked words for slow-control readback.

---
 rtl/prbs_checker_multi.sv | 239 +++++++++++++++++++++++
 tb/tb_prbs_checker_multi.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker_multi.sv
// prbs_checker_multi
// Self-synchronising PRBS7/15/23/31 checker for the ETROC2 readout link test
// path. Every accepted word is compared against a prediction that is seeded
// from the last 31 received bits. The result is reported per bit and per word.
// A search/lock state machine qualifies the link. Three saturating counters
// accumulate statistics while the link is locked.
//
// Ports
//   clk            word clock, the only clock
//   rst            synchronous active-high reset
//   din_valid      din carries a word this cycle
//   din            received word, bit 0 earliest in time
//   prbs_sel       0=PRBS7 1=PRBS15 2=PRBS23 3=PRBS31
//   resync         pulse, forces re-acquisition from IDLE
//   cnt_clear      pulse, zeroes the three statistics counters
//   out_valid      outputs below describe the word accepted last cycle
//   prbs_exp       predicted word
//   err_bits       prbs_exp ^ din
//   err_word_cnt   population count of err_bits
//   locked         checker is in LOCKED
//   bit_err_total  saturating sum of err_word_cnt over locked words
//   errword_total  saturating count of errored locked words
//   word_total     saturating count of locked words
module prbs_checker_multi #(
  parameter int DATA_WIDTH   = 32,
  parameter int CNT_WIDTH    = 32,
  parameter int LOCK_WORDS   = 4,
  parameter int UNLOCK_WORDS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            din_valid,
  input  logic [DATA_WIDTH-1:0]           din,
  input  logic [1:0]                      prbs_sel,
  input  logic                            resync,
  input  logic                            cnt_clear,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           prbs_exp,
  output logic [DATA_WIDTH-1:0]           err_bits,
  output logic [$clog2(DATA_WIDTH+1)-1:0] err_word_cnt,
  output logic                            locked,
  output logic [CNT_WIDTH-1:0]            bit_err_total,
  output logic [CNT_WIDTH-1:0]            errword_total,
  output logic [CNT_WIDTH-1:0]            word_total
);

  localparam int ECW   = $clog2(DATA_WIDTH+1);
  localparam int SUM_W = ((CNT_WIDTH > ECW) ? CNT_WIDTH : ECW) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [30:0]           hist_q, hist_d;
  logic [7:0]            goodCnt_q, goodCnt_d;
  logic [7:0]            badCnt_q, badCnt_d;
  logic [1:0]            sel_q;
  logic                  outValid_q, outValid_d;
  logic [DATA_WIDTH-1:0] prbsExp_q, prbsExp_d;
  logic [DATA_WIDTH-1:0] errBits_q, errBits_d;
  logic [ECW-1:0]        errCnt_q, errCnt_d;
  logic [CNT_WIDTH-1:0]  bitErrTot_q, bitErrTot_d;
  logic [CNT_WIDTH-1:0]  errWordTot_q, errWordTot_d;
  logic [CNT_WIDTH-1:0]  wordTot_q, wordTot_d;

  logic [DATA_WIDTH+30:0] ext;
  logic [DATA_WIDTH-1:0]  predWord;
  logic [DATA_WIDTH-1:0]  errWord;
  logic [ECW-1:0]         errCnt;
  logic                   selChange;
  logic                   resyncAll;
  logic                   cleanWord;

  // Saturating add. The sum is formed wide enough that neither operand can
  // overflow before the clamp is applied. This matters when the popcount is
  // wider than a narrow counter.
  function automatic logic [CNT_WIDTH-1:0] satAdd(input logic [CNT_WIDTH-1:0] base,
                                                  input logic [ECW-1:0]       inc);
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] lim;
    sum = SUM_W'(base) + SUM_W'(inc);
    lim = SUM_W'({CNT_WIDTH{1'b1}});
    if (sum > lim) return {CNT_WIDTH{1'b1}};
    return sum[CNT_WIDTH-1:0];
  endfunction

  // Prediction chain: the low 31 bits of ext hold history, oldest in bit 0.
  // Each new bit is derived from earlier chain bits, including bits
  // predicted earlier in the same word. Because of this, a received error
  // never feeds back into the word it is in.
  always_comb begin
    ext = '0;
    ext[30:0] = hist_q;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      case (sel_q)
        2'd0:    ext[31+i] = ext[31+i-7]  ^ ext[31+i-6];
        2'd1:    ext[31+i] = ext[31+i-15] ^ ext[31+i-14];
        2'd2:    ext[31+i] = ext[31+i-23] ^ ext[31+i-18];
        default: ext[31+i] = ext[31+i-31] ^ ext[31+i-28];
      endcase
    end
    predWord = ext[31 +: DATA_WIDTH];
  end

  // Per-word error vector and its population count.
  always_comb begin
    errWord = predWord ^ din;
    errCnt  = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      errCnt = errCnt + ECW'(errWord[i]);
    end
  end

  // A change of the polynomial select behaves exactly like a resync pulse.
  // An all-zero word is never treated as clean, so a dead link cannot hold
  // or gain lock.
  assign selChange = (prbs_sel != sel_q);
  assign resyncAll = resync | selChange;
  assign cleanWord = (errCnt == '0) && (din != '0);

  // Next-state logic for the search/lock FSM, the history, the per-word
  // results and the statistics counters. A resync discards the word in the
  // same cycle and keeps the counters. A clear forms the base that the
  // same-cycle locked word adds to.
  always_comb begin
    state_d      = state_q;
    hist_d       = hist_q;
    goodCnt_d    = goodCnt_q;
    badCnt_d     = badCnt_q;
    outValid_d   = 1'b0;
    prbsExp_d    = prbsExp_q;
    errBits_d    = errBits_q;
    errCnt_d     = errCnt_q;
    bitErrTot_d  = bitErrTot_q;
    errWordTot_d = errWordTot_q;
    wordTot_d    = wordTot_q;

    if (resyncAll) begin
      state_d   = IDLE;
      goodCnt_d = '0;
      badCnt_d  = '0;
    end else begin
      if (cnt_clear) begin
        bitErrTot_d  = '0;
        errWordTot_d = '0;
        wordTot_d    = '0;
      end
      if (din_valid) begin
        hist_d     = din[DATA_WIDTH-1 -: 31];
        outValid_d = 1'b1;
        prbsExp_d  = predWord;
        errBits_d  = errWord;
        errCnt_d   = errCnt;
        case (state_q)
          IDLE: begin
            errBits_d = '0;
            errCnt_d  = '0;
            state_d   = SEARCH;
            goodCnt_d = '0;
          end
          SEARCH: begin
            if (cleanWord) begin
              if (({1'b0, goodCnt_q} + 9'd1) >= 9'(LOCK_WORDS)) begin
                state_d   = LOCKED;
                goodCnt_d = '0;
                badCnt_d  = '0;
              end else begin
                goodCnt_d = goodCnt_q + 8'd1;
              end
            end else begin
              goodCnt_d = '0;
            end
          end
          LOCKED: begin
            wordTot_d    = satAdd(wordTot_d, ECW'(1));
            bitErrTot_d  = satAdd(bitErrTot_d, errCnt);
            errWordTot_d = satAdd(errWordTot_d, ECW'(errCnt != '0));
            if (cleanWord) begin
              badCnt_d = '0;
            end else if (({1'b0, badCnt_q} + 9'd1) >= 9'(UNLOCK_WORDS)) begin
              state_d   = SEARCH;
              goodCnt_d = '0;
              badCnt_d  = '0;
            end else begin
              badCnt_d = badCnt_q + 8'd1;
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hist_q       <= '0;
      goodCnt_q    <= '0;
      badCnt_q     <= '0;
      sel_q        <= 2'd0;
      outValid_q   <= 1'b0;
      prbsExp_q    <= '0;
      errBits_q    <= '0;
      errCnt_q     <= '0;
      bitErrTot_q  <= '0;
      errWordTot_q <= '0;
      wordTot_q    <= '0;
    end else begin
      state_q      <= state_d;
      hist_q       <= hist_d;
      goodCnt_q    <= goodCnt_d;
      badCnt_q     <= badCnt_d;
      sel_q        <= prbs_sel;
      outValid_q   <= outValid_d;
      prbsExp_q    <= prbsExp_d;
      errBits_q    <= errBits_d;
      errCnt_q     <= errCnt_d;
      bitErrTot_q  <= bitErrTot_d;
      errWordTot_q <= errWordTot_d;
      wordTot_q    <= wordTot_d;
    end
  end

  assign out_valid     = outValid_q;
  assign prbs_exp      = prbsExp_q;
  assign err_bits      = errBits_q;
  assign err_word_cnt  = errCnt_q;
  assign locked        = (state_q == LOCKED);
  assign bit_err_total = bitErrTot_q;
  assign errword_total = errWordTot_q;
  assign word_total    = wordTot_q;

endmodule

// File: tb/tb_prbs_checker_multi.sv
// tb_prbs_checker_multi
// Directed bench for prbs_checker_multi. The bench runs two instances side
// by side on the same stimulus: one has 32-bit counters and one has 4-bit
// counters, so that saturation can be observed. The PRBS source is a serial
// Fibonacci generator kept in the bench.
module tb_prbs_checker_multi;

  logic        clk;
  logic        rst;
  logic        din_valid;
  logic [31:0] din;
  logic [1:0]  prbs_sel;
  logic        resync;
  logic        cnt_clear;

  logic        outValid, outValid4;
  logic [31:0] prbsExp, prbsExp4;
  logic [31:0] errBits, errBits4;
  logic [5:0]  errCnt, errCnt4;
  logic        lockedO, locked4;
  logic [31:0] bitErrTot, errWordTot, wordTot;
  logic [3:0]  bitErrTot4, errWordTot4, wordTot4;

  int checks = 0;
  int errors = 0;

  logic [30:0] gen;
  int          genA;
  int          genB;
  logic [31:0] w;
  int          pcZero;

  prbs_checker_multi #(.DATA_WIDTH(32), .CNT_WIDTH(32), .LOCK_WORDS(4), .UNLOCK_WORDS(4)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .prbs_sel(prbs_sel),
    .resync(resync), .cnt_clear(cnt_clear), .out_valid(outValid), .prbs_exp(prbsExp),
    .err_bits(errBits), .err_word_cnt(errCnt), .locked(lockedO),
    .bit_err_total(bitErrTot), .errword_total(errWordTot), .word_total(wordTot)
  );

  prbs_checker_multi #(.DATA_WIDTH(32), .CNT_WIDTH(4), .LOCK_WORDS(4), .UNLOCK_WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .prbs_sel(prbs_sel),
    .resync(resync), .cnt_clear(cnt_clear), .out_valid(outValid4), .prbs_exp(prbsExp4),
    .err_bits(errBits4), .err_word_cnt(errCnt4), .locked(locked4),
    .bit_err_total(bitErrTot4), .errword_total(errWordTot4), .word_total(wordTot4)
  );

  // Free-running word clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Produces the next 32 source bits in time order. gen[0] holds the most
  // recent bit.
  task automatic genWord(output logic [31:0] word);
    logic b;
    for (int i = 0; i < 32; i++) begin
      b = gen[genA-1] ^ gen[genB-1];
      gen = {gen[29:0], b};
      word[i] = b;
    end
  endtask

  // Drives one cycle of input. It returns 1 ns after the edge that sampled
  // the input, so the registered outputs then describe that word.
  task automatic applyStimulus(input logic valid, input logic [31:0] data);
    din_valid = valid;
    din       = data;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Directed sequence.
  initial begin
    rst       = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    prbs_sel  = 2'd0;
    resync    = 1'b0;
    cnt_clear = 1'b0;
    gen       = 31'h1;
    genA      = 7;
    genB      = 6;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 64'(outValid), 64'd0);
    checkOutput("rst_locked", 64'(lockedO), 64'd0);
    checkOutput("rst_err_bits", 64'(errBits), 64'd0);
    checkOutput("rst_prbs_exp", 64'(prbsExp), 64'd0);
    checkOutput("rst_err_cnt", 64'(errCnt), 64'd0);
    checkOutput("rst_word_total", 64'(wordTot), 64'd0);
    checkOutput("rst_bit_err_total", 64'(bitErrTot), 64'd0);
    rst = 1'b0;

    $display("[TB] acquire PRBS7");
    for (int k = 1; k <= 5; k++) begin
      genWord(w);
      applyStimulus(1'b1, w);
      if (k == 1) begin
        checkOutput("idle_out_valid", 64'(outValid), 64'd1);
        checkOutput("idle_err_bits", 64'(errBits), 64'd0);
      end
      if (k == 4) checkOutput("prelock_locked", 64'(lockedO), 64'd0);
    end
    checkOutput("lock_locked", 64'(lockedO), 64'd1);
    checkOutput("lock_err_cnt", 64'(errCnt), 64'd0);
    checkOutput("lock_word_total", 64'(wordTot), 64'd0);
    checkOutput("lock_word_total4", 64'(wordTot4), 64'd0);

    $display("[TB] saturation and clear");
    for (int k = 0; k < 20; k++) begin
      genWord(w);
      applyStimulus(1'b1, w);
    end
    checkOutput("sat_word_total", 64'(wordTot), 64'd20);
    checkOutput("sat_word_total4", 64'(wordTot4), 64'd15);
    checkOutput("sat_bit_err_total", 64'(bitErrTot), 64'd0);
    genWord(w);
    cnt_clear = 1'b1;
    applyStimulus(1'b1, w);
    cnt_clear = 1'b0;
    checkOutput("clr_word_total", 64'(wordTot), 64'd1);
    checkOutput("clr_word_total4", 64'(wordTot4), 64'd1);
    checkOutput("clr_locked", 64'(lockedO), 64'd1);

    applyStimulus(1'b0, 32'hDEADBEEF);
    checkOutput("novalid_out_valid", 64'(outValid), 64'd0);
    checkOutput("novalid_word_total", 64'(wordTot), 64'd1);

    $display("[TB] single bit errors");
    genWord(w);
    applyStimulus(1'b1, w ^ 32'h0000_0020);
    checkOutput("flip5_prbs_exp", 64'(prbsExp), 64'(w));
    checkOutput("flip5_err_bits", 64'(errBits), 64'h20);
    checkOutput("flip5_err_cnt", 64'(errCnt), 64'd1);
    checkOutput("flip5_bit_err_total", 64'(bitErrTot), 64'd1);
    checkOutput("flip5_errword_total", 64'(errWordTot), 64'd1);
    genWord(w);
    applyStimulus(1'b1, w);
    checkOutput("after5_err_cnt", 64'(errCnt), 64'd0);
    checkOutput("after5_word_total", 64'(wordTot), 64'd3);

    genWord(w);
    applyStimulus(1'b1, w ^ 32'h8000_0000);
    checkOutput("flip31_err_bits", 64'(errBits), 64'h8000_0000);
    genWord(w);
    applyStimulus(1'b1, w);
    checkOutput("hist_err_bits", 64'(errBits), 64'h689E_2860);
    checkOutput("hist_err_cnt", 64'(errCnt), 64'd12);
    checkOutput("hist_bit_err_total", 64'(bitErrTot), 64'd14);
    checkOutput("hist_errword_total", 64'(errWordTot), 64'd3);
    checkOutput("hist_locked", 64'(lockedO), 64'd1);
    genWord(w);
    applyStimulus(1'b1, w);
    checkOutput("recover_err_cnt", 64'(errCnt), 64'd0);
    checkOutput("recover_word_total", 64'(wordTot), 64'd6);

    $display("[TB] dead link unlock");
    genWord(w);
    pcZero = $countones(w);
    applyStimulus(1'b1, 32'h0);
    checkOutput("zero1_err_bits", 64'(errBits), 64'(w));
    checkOutput("zero1_err_cnt", 64'(errCnt), 64'(pcZero));
    applyStimulus(1'b1, 32'h0);
    checkOutput("zero2_err_cnt", 64'(errCnt), 64'd0);
    applyStimulus(1'b1, 32'h0);
    checkOutput("zero3_locked", 64'(lockedO), 64'd1);
    applyStimulus(1'b1, 32'h0);
    checkOutput("zero4_locked", 64'(lockedO), 64'd0);
    checkOutput("zero4_word_total", 64'(wordTot), 64'd10);
    checkOutput("zero4_errword_total", 64'(errWordTot), 64'd4);
    checkOutput("zero4_bit_err_total", 64'(bitErrTot), 64'(14 + pcZero));
    checkOutput("zero4_bit_err_total4", 64'(bitErrTot4), 64'd15);

    for (int k = 1; k <= 5; k++) begin
      genWord(w);
      applyStimulus(1'b1, w);
      if (k == 1) checkOutput("relock1_err_bits", 64'(errBits), 64'(w));
      if (k == 4) checkOutput("relock4_locked", 64'(lockedO), 64'd0);
    end
    checkOutput("relock_locked", 64'(lockedO), 64'd1);
    checkOutput("relock_word_total", 64'(wordTot), 64'd10);

    $display("[TB] switch to PRBS31");
    gen  = 31'h2A5F_0C93;
    genA = 31;
    genB = 28;
    genWord(w);
    prbs_sel = 2'd3;
    applyStimulus(1'b1, w);
    checkOutput("sel_out_valid", 64'(outValid), 64'd0);
    checkOutput("sel_locked", 64'(lockedO), 64'd0);
    for (int k = 1; k <= 5; k++) begin
      genWord(w);
      applyStimulus(1'b1, w);
      if (k == 1) checkOutput("p31_idle_out_valid", 64'(outValid), 64'd1);
      if (k == 4) checkOutput("p31_prelock_locked", 64'(lockedO), 64'd0);
    end
    checkOutput("p31_locked", 64'(lockedO), 64'd1);
    checkOutput("p31_word_total", 64'(wordTot), 64'd10);
    checkOutput("p31_errword_total", 64'(errWordTot), 64'd4);
    genWord(w);
    applyStimulus(1'b1, w);
    checkOutput("p31_prbs_exp", 64'(prbsExp), 64'(w));
    checkOutput("p31_err_cnt", 64'(errCnt), 64'd0);
    checkOutput("p31_word_total_inc", 64'(wordTot), 64'd11);

    din_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
